// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment table, idle pin constants and scan state type
package seg7_pkg;

    localparam logic [0:6] SEG_OFF = 7'b1111111;
    localparam logic [3:0] AN_OFF  = 4'b1111;

    localparam logic [0:6] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b1111111
    };

    typedef enum logic {S_ON, S_DEAD} state_t;

endpackage

// File: rtl/seg7_hex_decode.sv
// seg7_hex_decode: nibble to active-low segments; F decodes to dark
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [0:6] seg
);

    assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: 4-digit multiplexed 7-seg driver with frame-aligned load and blanking
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int PRESCALE     = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    input  logic        lzb_en,
    input  logic [3:0]  blank_mask,
    output logic [0:6]  seg,
    output logic [3:0]  an,
    output logic        frame_done
);

    localparam logic [19:0] ON_LAST   = 20'(PRESCALE - BLANK_CYCLES - 1);
    localparam logic [19:0] DEAD_LAST = 20'(BLANK_CYCLES - 1);

    state_t      state, state_nx;
    logic [19:0] cnt, cnt_nx;
    logic [1:0]  digit, digit_nx;
    logic [15:0] disp, pend;
    logic        pend_full;
    logic [3:0]  nib, lz;
    logic [0:6]  dec;
    logic        dark;

    assign frame_done = state == S_DEAD && cnt == DEAD_LAST && digit == 2'd3;
    assign load_ready = !pend_full;
    assign nib        = disp[{digit, 2'b00} +: 4];
    assign lz[3]      = disp[15:12] == 4'h0;
    assign lz[2]      = lz[3] && disp[11:8] == 4'h0;
    assign lz[1]      = lz[2] && disp[7:4] == 4'h0;
    assign lz[0]      = 1'b0;
    assign dark       = blank_mask[digit] || nib == 4'hF || (lzb_en && lz[digit]);

    seg7_hex_decode u_dec (.nib(nib), .seg(dec));

    // slot sequencing: ON for PRESCALE-BLANK_CYCLES cycles, then dead time, then next digit
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 20'd1;
        digit_nx = digit;
        if (state == S_ON && cnt == ON_LAST) begin
            state_nx = S_DEAD;
            cnt_nx   = '0;
        end else if (state == S_DEAD && cnt == DEAD_LAST) begin
            state_nx = S_ON;
            cnt_nx   = '0;
            digit_nx = digit + 2'd1;
        end
    end

    // scan state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_ON;
            cnt   <= '0;
            digit <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            digit <= digit_nx;
        end
    end

    // pending word handshake; commit to display only at the frame boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            disp      <= '0;
            pend      <= '0;
            pend_full <= 1'b0;
        end else if (frame_done && pend_full) begin
            disp      <= pend;
            pend_full <= 1'b0;
        end else if (load_valid && !pend_full) begin
            pend      <= load_data;
            pend_full <= 1'b1;
        end
    end

    // registered pins: lit digit during ON, everything dark during dead time
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            an  <= AN_OFF;
            seg <= SEG_OFF;
        end else begin
            an  <= state == S_ON ? ~(4'b0001 << digit) : AN_OFF;
            seg <= (state == S_ON && !dark) ? dec : SEG_OFF;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench with time-indexed reference model
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_ready;
    logic        lzb_en = 1'b0;
    logic [3:0]  blank_mask = '0;
    logic [0:6]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    seg7_scan_driver #(.PRESCALE(8), .BLANK_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
        .load_ready(load_ready), .lzb_en(lzb_en), .blank_mask(blank_mask),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b1111111
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model: position within the frame is derived from cycles since reset
    int          t = 0;
    logic [15:0] mdisp = '0, mpend = '0;
    logic        mfull = 1'b0;
    logic        started = 1'b0;
    logic [10:0] exp_q [$];
    int          m_slot, m_ph;
    logic [3:0]  m_nib, m_an;
    logic        m_dark;

    always @(posedge clk) begin
        started = 1'b1;
        if (!rst_n) begin
            exp_q.push_back({4'hF, 7'h7F});
            t = 0;
            mdisp = '0;
            mfull = 1'b0;
        end else begin
            m_slot = (t / 8) % 4;
            m_ph   = t % 8;
            m_nib  = mdisp[m_slot*4 +: 4];
            m_dark = blank_mask[m_slot] || m_nib == 4'hF ||
                     (lzb_en && m_slot > 0 && (mdisp >> (4*m_slot)) == 16'h0);
            m_an   = ~(4'b0001 << m_slot);
            exp_q.push_back(m_ph < 6 ? {m_an, m_dark ? 7'h7F : hex_tbl[m_nib]} : {4'hF, 7'h7F});
            if (t % 32 == 31 && mfull) begin
                mdisp = mpend;
                mfull = 1'b0;
            end else if (load_valid && !mfull) begin
                mpend = load_data;
                mfull = 1'b1;
            end
            t++;
        end
    end

    logic [10:0] exp_pins;
    always @(negedge clk) begin
        if (started) begin
            if (exp_q.size() > 0) begin
                exp_pins = exp_q.pop_front();
                check("pins", {21'b0, an, seg}, {21'b0, exp_pins});
            end
            check("load_ready", {31'b0, load_ready}, {31'b0, !mfull});
            check("frame_done", {31'b0, frame_done}, {31'b0, t % 32 == 31});
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 100);
        check("frame_seen", {31'b0, frame_done}, 32'd1);
    endtask

    task automatic wait_an(input logic [3:0] want);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (an !== want && n < 100);
        check("an_seen", {28'b0, an}, {28'b0, want});
    endtask

    task automatic load(input logic [15:0] d);
        load_valid = 1'b1;
        load_data  = d;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    int n;

    initial begin
        cycles(3);
        check("rst_an", {28'b0, an}, 32'hF);
        check("rst_seg", {25'b0, seg}, 32'h7F);
        check("rst_ready", {31'b0, load_ready}, 32'd1);
        rst_n = 1'b1;
        cycles(1);
        check("first_an", {28'b0, an}, 32'hE);
        check("first_seg", {25'b0, seg}, 32'h01);

        load(16'h1234);
        cycles(64);
        wait_frame(n);
        wait_frame(n);
        check("frame_period", n, 32);

        cycles(10);
        load(16'hABCD);
        check("ready_drop", {31'b0, load_ready}, 32'd0);
        load_valid = 1'b1;
        load_data  = 16'h5555;
        cycles(3);
        load_valid = 1'b0;
        wait_frame(n);
        check("ready_at_commit", {31'b0, load_ready}, 32'd0);
        cycles(1);
        check("ready_after_commit", {31'b0, load_ready}, 32'd1);
        cycles(34);

        wait_frame(n);
        load(16'h0007);
        check("ready_boundary_load", {31'b0, load_ready}, 32'd0);
        cycles(70);

        load(16'h0070);
        cycles(70);
        lzb_en = 1'b1;
        cycles(40);
        blank_mask = 4'b0001;
        cycles(2);
        wait_an(4'b1110);
        check("dark_d0_seg", {25'b0, seg}, 32'h7F);
        cycles(40);

        blank_mask = 4'b0000;
        lzb_en = 1'b0;
        wait_an(4'b1011);
        load(16'h9999);
        check("pend_before_rst", {31'b0, load_ready}, 32'd0);
        rst_n = 1'b0;
        cycles(2);
        check("midrst_an", {28'b0, an}, 32'hF);
        check("midrst_seg", {25'b0, seg}, 32'h7F);
        check("midrst_ready", {31'b0, load_ready}, 32'd1);
        rst_n = 1'b1;
        cycles(1);
        check("resume_seg", {25'b0, seg}, 32'h01);
        cycles(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
